// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the hazard/operand-delivery unit.
// Stage indices follow producer age: exe is the youngest source.
package pipe_hazard_ctrl_pkg;

    localparam int STG_EXE  = 0;
    localparam int STG_MEM  = 1;
    localparam int STG_WB   = 2;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        SEL_ZERO  = 2'd0,
        SEL_RF    = 2'd1,
        SEL_STAGE = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Resolves one source operand: zero, youngest matching producer, or regfile data.
// Purely combinational; flags when the chosen producer's value is not final yet.
module fwd_select
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3
) (
    input  logic                         used_i,
    input  logic [REG_AW-1:0]            addr_i,
    input  logic [XLEN-1:0]              rf_data_i,
    input  logic [FWD_STAGES*REG_AW-1:0] stg_rdaddr_i,
    input  logic [FWD_STAGES*XLEN-1:0]   stg_rddata_i,
    input  logic [FWD_STAGES-1:0]        stg_we_i,
    input  logic [FWD_STAGES-1:0]        stg_rdy_i,
    output logic [XLEN-1:0]              data_o,
    output logic                         not_rdy_o
);

    fwd_sel_t        sel;
    logic [XLEN-1:0] stg_dat;
    logic            stg_nrdy;

    always_comb begin
        sel      = SEL_ZERO;
        stg_dat  = '0;
        stg_nrdy = 1'b0;
        if (used_i && (int'(addr_i) != ZERO_REG)) begin
            sel = SEL_RF;
            // Walk oldest to youngest so the lowest index overrides.
            for (int i = FWD_STAGES - 1; i >= 0; i--) begin
                if (stg_we_i[i] && (stg_rdaddr_i[i*REG_AW +: REG_AW] == addr_i)) begin
                    sel      = SEL_STAGE;
                    stg_dat  = stg_rddata_i[i*XLEN +: XLEN];
                    stg_nrdy = ~stg_rdy_i[i];
                end
            end
        end
    end

    always_comb begin
        data_o    = '0;
        not_rdy_o = 1'b0;
        case (sel)
            SEL_RF:    data_o = rf_data_i;
            SEL_STAGE: begin
                data_o    = stg_dat;
                not_rdy_o = stg_nrdy;
            end
            default: begin
                data_o    = '0;
                not_rdy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, multi-cycle scoreboard and registered ID/EX operand stage.
// Stall/flush are combinational; operands appear one cycle after acceptance.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3,
    parameter int CNT_W      = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         id_valid_i,
    input  logic [REG_AW-1:0]            id_rs1_i,
    input  logic [REG_AW-1:0]            id_rs2_i,
    input  logic                         id_rs1_used_i,
    input  logic                         id_rs2_used_i,
    input  logic [XLEN-1:0]              id_rs1_data_i,
    input  logic [XLEN-1:0]              id_rs2_data_i,
    input  logic [REG_AW-1:0]            id_rd_i,
    input  logic                         id_md_i,
    input  logic [FWD_STAGES*REG_AW-1:0] stg_rdaddr_i,
    input  logic [FWD_STAGES*XLEN-1:0]   stg_rddata_i,
    input  logic [FWD_STAGES-1:0]        stg_we_i,
    input  logic [FWD_STAGES-1:0]        stg_rdy_i,
    input  logic                         md_done_i,
    input  logic [REG_AW-1:0]            md_rd_i,
    input  logic                         redirect_i,
    output logic                         stall_o,
    output logic                         flush_o,
    output logic                         ex_valid_o,
    output logic [XLEN-1:0]              ex_op1_o,
    output logic [XLEN-1:0]              ex_op2_o,
    output logic [CNT_W-1:0]             stall_cnt_o
);

    localparam int NREG = 1 << REG_AW;

    logic [XLEN-1:0]  op1, op2;
    logic             op1_nrdy, op2_nrdy;
    logic             md_hazard, accept;

    logic [NREG-1:0]  busy_q, busy_d;
    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_fwd_rs1 (
        .used_i(id_rs1_used_i), .addr_i(id_rs1_i), .rf_data_i(id_rs1_data_i),
        .stg_rdaddr_i(stg_rdaddr_i), .stg_rddata_i(stg_rddata_i),
        .stg_we_i(stg_we_i), .stg_rdy_i(stg_rdy_i),
        .data_o(op1), .not_rdy_o(op1_nrdy)
    );

    fwd_select #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_fwd_rs2 (
        .used_i(id_rs2_used_i), .addr_i(id_rs2_i), .rf_data_i(id_rs2_data_i),
        .stg_rdaddr_i(stg_rdaddr_i), .stg_rddata_i(stg_rddata_i),
        .stg_we_i(stg_we_i), .stg_rdy_i(stg_rdy_i),
        .data_o(op2), .not_rdy_o(op2_nrdy)
    );

    // busy_q[0] is never set, so the WAW term needs no zero-register guard.
    always_comb begin
        md_hazard = (id_rs1_used_i && busy_q[id_rs1_i])
                  | (id_rs2_used_i && busy_q[id_rs2_i])
                  | busy_q[id_rd_i];
        stall_o   = id_valid_i & (op1_nrdy | op2_nrdy | md_hazard) & ~redirect_i;
        flush_o   = redirect_i;
        accept    = id_valid_i & ~stall_o & ~redirect_i;
    end

    always_comb begin
        busy_d = busy_q;
        if (md_done_i) busy_d[md_rd_i] = 1'b0;
        if (accept && id_md_i && (int'(id_rd_i) != ZERO_REG)) busy_d[id_rd_i] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;

        ex_valid_d = 1'b0;
        ex_op1_d   = '0;
        ex_op2_d   = '0;
        if (!(redirect_i || stall_o)) begin
            ex_valid_d = id_valid_i;
            ex_op1_d   = op1;
            ex_op2_d   = op2;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            ex_valid_q  <= 1'b0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            ex_valid_q  <= ex_valid_d;
            ex_op1_q    <= ex_op1_d;
            ex_op2_q    <= ex_op2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid_o  = ex_valid_q;
    assign ex_op1_o    = ex_op1_q;
    assign ex_op2_o    = ex_op2_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and operand-delivery unit for the five-stage core. It generalises the fixed three-stage, purely combinational operand forwarding to FWD_STAGES producer stages. It adds load-use stall detection, a multi-cycle-unit scoreboard, redirect flushing, and a registered ID/EX operand stage that inserts bubbles. It sits between decode and exe, replacing the forwarding instance and owning the ID/EX operand register.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width; register 0 is hard-wired zero
- FWD_STAGES, 3, number of forwarding sources; index 0 is the youngest stage (exe)
- CNT_W, 32, width of the stall performance counter

Ports (the already-decided point: one clock `clk_i`; reset `rst_i` is synchronous and active-high):
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  decode holds a valid instruction
- id_rs1_i, id_rs2_i  in  REG_AW  source addresses
- id_rs1_used_i, id_rs2_used_i  in  1  source actually read
- id_rs1_data_i, id_rs2_data_i  in  XLEN  regfile read data
- id_rd_i  in  REG_AW  destination of the decode instruction
- id_md_i  in  1  decode instruction issues to the multi-cycle unit
- stg_rdaddr_i  in  FWD_STAGES*REG_AW  packed producer rd addresses
- stg_rddata_i  in  FWD_STAGES*XLEN  packed producer data
- stg_we_i  in  FWD_STAGES  producer write enable
- stg_rdy_i  in  FWD_STAGES  data is final at that stage; 0 for a load in exe
- md_done_i  in  1  multi-cycle result written back this cycle
- md_rd_i  in  REG_AW  register completed by md_done_i
- redirect_i  in  1  branch/jump taken in exe
- stall_o  out  1  hold PC and IF/ID
- flush_o  out  1  kill the IF/ID instruction
- ex_valid_o  out  1  ID/EX holds a valid instruction
- ex_op1_o, ex_op2_o  out  XLEN  registered resolved operands
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Operand resolution per source:
  - Address 0 or source not used resolves to 0.
  - Otherwise, take the lowest-index stage with we=1 and a matching address.
  - If no stage matches, take the regfile data.
- Data hazard: the selected stage has rdy=0.
- Scoreboard: busy bit per register, excluding register 0.
  - Set on an accepted issue with id_md_i=1 and id_rd_i≠0.
  - Cleared on md_done_i for md_rd_i.
  - Set and clear of the same register in the same cycle: set wins.
- MD hazard: a used source is busy, or id_rd_i is busy (WAW).
- stall_o = id_valid_i & (data hazard | MD hazard) & ~redirect_i.
- flush_o = redirect_i.
- ID/EX register update each cycle:
  - redirect_i or stall_o: ex_valid_o←0 (bubble) and operands←0.
  - Else: ex_valid_o←id_valid_i and operands←resolved values.
- stall_cnt_o increments on each stall_o cycle and saturates at all-ones.
- Reset: ex_valid_o=0, ex_op1_o=0, ex_op2_o=0, stall_cnt_o=0, all busy bits 0.
  - stall_o and flush_o are 0 whenever inputs are idle.
  - Reset mid-stall drops every pending hazard the next cycle.

## Timing
- stall_o and flush_o are combinational from the current-cycle inputs; no registered delay.
- ID/EX operands have one-cycle latency: values accepted in cycle N appear in cycle N+1.
- Load-use costs exactly one stall cycle. In the next cycle the load is in mem with rdy=1 and the value is forwarded.
- MD dependency stalls until the cycle after md_done_i. That cycle's write reaches the regfile or the wb stage forward path.
- redirect_i has priority over stall. When both are asserted, the bubble is inserted and no stall is counted.

## Structure
- Shared package defines: stage index constants (STG_EXE=0, STG_MEM=1, STG_WB=2), the zero-register constant, and a mux-select typedef.
- One natural sub-module: `fwd_select`. It is combinational, one instance per source operand, and performs the priority match plus the not-ready flag.
- The scoreboard and ID/EX register live in the top of this block.

## Test plan
- Register x5 is written in exe with value 0xAA and in mem with value 0xBB; decode reads x5 → ex_op1_o=0xAA next cycle, no stall.
- Load to x7 in exe (rdy=0); decode uses x7 → stall_o=1 for one cycle and ex_valid_o=0. The next cycle forwards the mem data and stall_cnt_o=1.
- An MD issue sets x9 busy, then a consumer of x9 is decoded → stall held until md_done_i with md_rd_i=9, released the following cycle.
- A source of x0 while x0 appears at a producer with we=1 and data 0xFFFF → operand 0, no stall.
- redirect_i together with a load-use hazard → flush_o=1, stall_o=0, ex_valid_o=0 next cycle, counter unchanged.
- rst_i asserted while x3 is busy and a stall is in progress → after one cycle all outputs are zero and x3 is no longer busy.
